alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the datapath ALU. It accepts one operation per `start` pulse. Single-cycle operations complete on the next clock edge. Unsigned multiply runs iteratively over W cycles with a busy/done handshake. Results and Z/C/N/V flags are registered and held until the next completed operation; the block sits between the accumulator/register-file read ports and the accumulator write-back.

## Interface
- `W`, default 8: operand and result width; must be at least 2.
- `CLK  in  1`: single clock. All state updates on the rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `start  in  1`: request an operation. Sampled only when `busy`=0.
- `OP  in  4`: opcode, sampled with `start`.
- `acc_in  in  W`: operand A (accumulator).
- `reg_in  in  W`: operand B (register file or shift amount).
- `OUT  out  W`: registered result, low half for MUL.
- `OUT_HI  out  W`: registered high half of the MUL product; 0 for all other ops.
- `z`, `c`, `n`, `v  out  1 each`: registered zero, carry/borrow, negative and overflow flags.
- `busy  out  1`: high while a MUL is in progress.
- `done  out  1`: one-cycle pulse when the result and flags have just been updated.

## Operation
- States are IDLE and MUL. Every opcode except MUL completes in IDLE.
- Start acceptance: `start`=1 with `busy`=0 latches `OP`, `acc_in` and `reg_in`. `start` while `busy`=1 is ignored entirely; it is not queued.
- Opcodes, with z = (OUT==0) and n = OUT[W-1] unless stated otherwise:
  - 0010 ADD: {c,OUT} = A+B; v = signed overflow (A[W-1]==B[W-1] and OUT[W-1]!=A[W-1]).
  - 0011 SUB: {c,OUT} = A-B, so c=1 means borrow (A<B unsigned); v = signed overflow (A[W-1]!=B[W-1] and OUT[W-1]!=A[W-1]).
  - 0100 SHL, 0101 SHR (logical): shift amount is all of B, unsigned. If B>=W, OUT=0. c=v=0.
  - 1001 ASR (new): arithmetic right shift. If B>=W, OUT is every bit set to A[W-1]. c=v=0.
  - 0110 AND, 0111 OR, 1000 XOR: bitwise. c=v=0.
  - 1010 CMP: unsigned compare. OUT=0; z=(A==B); n=(A<B); c=v=0.
  - 1011 MUL (new): unsigned {OUT_HI,OUT} = A*B (2W bits); z = (full product==0); c = (OUT_HI!=0); n=v=0.
  - Any other opcode: OUT=OUT_HI=0, all flags 0, `done` still pulses.
- MUL uses shift-add, one multiplier bit per cycle (W iterations) with a 2W-bit accumulator. `OUT`, `OUT_HI` and the flags do not change until the final iteration.
- `OUT`, `OUT_HI` and the flags hold their last values between operations.

## Timing
- Reset (synchronous, takes effect at the edge where `reset`=1): `OUT`=`OUT_HI`=0, z=c=n=v=0, `busy`=0, `done`=0, state IDLE. Reset overrides `start` in the same cycle.
- Single-cycle ops: with `start` accepted at edge k, results and flags are valid after edge k and `done`=1 for exactly the cycle k..k+1. `busy` never rises.
  - Back-to-back `start` every cycle is legal, giving one result per cycle with `done` held high continuously.
- MUL: with `start` accepted at edge k, `busy`=1 after edge k.
  - Iterations run at edges k+1..k+W.
  - At edge k+W the results are written, `busy`=0 and `done`=1 for one cycle.
  - Latency is W cycles from acceptance to `done`.
- A new `start` may be accepted at the very edge where `done` rises after MUL, because `busy` is already 0 during that cycle.
- Reset during MUL: the operation is aborted, no `done` is produced, and the outputs take their reset values.
- `done` is never high in the same cycle as `busy`.

## Test plan
- W=8, ADD A=0x7F, B=0x01 -> next cycle OUT=0x80, n=1, v=1, c=0, z=0, `done` pulse of one cycle. SUB A=0x05, B=0x07 -> OUT=0xFE, c=1, n=1, v=0.
- Shifts, W=8: ASR A=0x90, B=2 -> OUT=0xE4. SHL A=0x81, B=9 -> OUT=0x00, z=1. SHR A=0x80, B=7 -> OUT=0x01. ASR A=0x80, B=200 -> OUT=0xFF.
- CMP, W=8: A=5, B=5 -> z=1, n=0, OUT=0. A=3, B=9 -> z=0, n=1. A=0xF0, B=0x01 -> z=0, n=0 (unsigned).
- MUL, W=8, A=200, B=3 -> `busy` high for 8 cycles, then OUT=0x58, OUT_HI=0x02, c=1, `done` pulse. A `start` with ADD issued mid-MUL is ignored, so no extra `done` appears and the result is unchanged.
- Reset asserted 4 cycles into MUL A=0xFF, B=0xFF -> next cycle `busy`=0, OUT=OUT_HI=0, all flags 0, and no `done` ever appears for that operation.
- W=16: MUL A=0xFFFF, B=0xFFFF -> after 16 cycles OUT=0x0001, OUT_HI=0xFFFE, c=1. ADD A=0xFFFF, B=1 -> OUT=0, z=1, c=1, v=0. Undefined opcode 0xF -> all outputs 0 with a `done` pulse.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/logic/shift/compare ops plus a
// W-cycle shift-add unsigned multiplier behind a busy/done handshake.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   OP,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] reg_in,
  output logic [W-1:0] OUT,
  output logic [W-1:0] OUT_HI,
  output logic         z,
  output logic         c,
  output logic         n,
  output logic         v,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
  localparam logic [W-1:0]  W_AMT     = W'(W);

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   out_q, out_d;
  logic [W-1:0]   out_hi_q, out_hi_d;
  logic           z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W:0]     add_s, sub_s;
  logic           shift_big_s;
  logic [W-1:0]   res_s;
  logic           rz_s, rc_s, rn_s, rv_s;
  logic [2*W-1:0] prod_sum_s;

  // Single-cycle result and flags straight from the live operands
  always_comb begin
    add_s       = {1'b0, acc_in} + {1'b0, reg_in};
    sub_s       = {1'b0, acc_in} - {1'b0, reg_in};
    shift_big_s = (reg_in >= W_AMT);
    res_s       = {W{1'b0}};
    rc_s        = 1'b0;
    rv_s        = 1'b0;
    rz_s        = 1'b0;
    rn_s        = 1'b0;
    case (OP)
      OP_ADD: begin
        res_s = add_s[W-1:0];
        rc_s  = add_s[W];
        rv_s  = (acc_in[W-1] == reg_in[W-1]) && (add_s[W-1] != acc_in[W-1]);
      end
      OP_SUB: begin
        res_s = sub_s[W-1:0];
        rc_s  = sub_s[W];
        rv_s  = (acc_in[W-1] != reg_in[W-1]) && (sub_s[W-1] != acc_in[W-1]);
      end
      OP_SHL: begin
        if (shift_big_s) res_s = {W{1'b0}};
        else             res_s = acc_in << reg_in;
      end
      OP_SHR: begin
        if (shift_big_s) res_s = {W{1'b0}};
        else             res_s = acc_in >> reg_in;
      end
      OP_ASR: begin
        if (shift_big_s) res_s = {W{acc_in[W-1]}};
        else             res_s = $signed(acc_in) >>> reg_in;
      end
      OP_AND:  res_s = acc_in & reg_in;
      OP_OR:   res_s = acc_in | reg_in;
      OP_XOR:  res_s = acc_in ^ reg_in;
      default: res_s = {W{1'b0}};
    endcase
    // CMP reports through z/n only; unknown opcodes clear every flag
    if (OP == OP_CMP) begin
      rz_s = (acc_in == reg_in);
      rn_s = (acc_in < reg_in);
    end else if ((OP >= OP_ADD) && (OP <= OP_ASR)) begin
      rz_s = (res_s == {W{1'b0}});
      rn_s = res_s[W-1];
    end else begin
      rz_s = 1'b0;
      rn_s = 1'b0;
    end
  end

  assign prod_sum_s = prod_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});

  // Next-state, operand latching and result write-back
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    z_d      = z_q;
    c_d      = c_q;
    n_d      = n_q;
    v_d      = v_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && (OP == OP_MUL)) begin
          state_d  = S_MUL;
          busy_d   = 1'b1;
          mcand_d  = {{W{1'b0}}, acc_in};
          mplier_d = reg_in;
          prod_d   = {(2*W){1'b0}};
          cnt_d    = {CW{1'b0}};
        end else if (start) begin
          done_d   = 1'b1;
          out_d    = res_s;
          out_hi_d = {W{1'b0}};
          z_d      = rz_s;
          c_d      = rc_s;
          n_d      = rn_s;
          v_d      = rv_s;
        end else begin
          done_d   = 1'b0;
        end
      end
      S_MUL: begin
        prod_d   = prod_sum_s;
        mcand_d  = {mcand_q[2*W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[W-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          out_d    = prod_sum_s[W-1:0];
          out_hi_d = prod_sum_s[2*W-1:W];
          z_d      = (prod_sum_s == {(2*W){1'b0}});
          c_d      = (prod_sum_s[2*W-1:W] != {W{1'b0}});
          n_d      = 1'b0;
          v_d      = 1'b0;
        end else begin
          busy_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= {W{1'b0}};
      out_hi_q <= {W{1'b0}};
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      mcand_q  <= {(2*W){1'b0}};
      mplier_q <= {W{1'b0}};
      prod_q   <= {(2*W){1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      z_q      <= z_d;
      c_q      <= c_d;
      n_q      <= n_d;
      v_q      <= v_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign OUT    = out_q;
  assign OUT_HI = out_hi_q;
  assign z      = z_q;
  assign c      = c_q;
  assign n      = n_q;
  assign v      = v_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
